simt_stack: RTL

Per-warp SIMT reconvergence stack for the SP. It consumes `BRA_PUSH` and `BRA_POP` requests from the branch unit and maintains each warp's active thread mask and divergence entries. It returns the next PC, the active mask and a flush indication to the fetch and issue logic. It also raises sticky `KIANA_SP_ERR_SIMT_STACK_*` and `KIANA_SP_ERR_BRANCH_UNIT_INVALID_OP` error bits.

---
 rtl/simt_stack.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/simt_stack.sv
`default_nettype none
// ============================================================================
//  Module   : simt_stack
//  Purpose  : Per-warp SIMT reconvergence stack. Handles divergent-branch
//             PUSH and join POP requests from the branch unit. Keeps each
//             warp's active thread mask and its stack of divergence entries.
//             Returns the next PC, the new mask and a fetch-flush indication.
//             Also keeps sticky error bits.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          : clock, asynchronous active-low reset
//    init_*              : warp launch (wid, initial mask); wins over requests
//    req_*               : branch request handshake, op, outcome and PCs
//    rsp_*               : registered one-cycle response (wid, mask, pc, flush)
//    active_mask_o       : flattened active mask of every warp
//    stack_empty_o       : per-warp sp==0
//    err_o / err_clr_i   : sticky error bits (0x20 ovf, 0x40 unf, 0x80 bad op)
// ============================================================================
module simt_stack #(
  parameter int NUM_WARP   = 8,
  parameter int NUM_THREAD = 32,
  parameter int DEPTH      = 16,
  parameter int XLEN       = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_valid_i,
  input  logic [$clog2(NUM_WARP)-1:0]    init_wid_i,
  input  logic [NUM_THREAD-1:0]          init_mask_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [$clog2(NUM_WARP)-1:0]    req_wid_i,
  input  logic [2:0]                     req_op_i,
  input  logic [NUM_THREAD-1:0]          req_taken_mask_i,
  input  logic [XLEN-1:0]                req_target_pc_i,
  input  logic [XLEN-1:0]                req_fallthru_pc_i,
  input  logic [XLEN-1:0]                req_reconv_pc_i,
  output logic                           rsp_valid_o,
  output logic [$clog2(NUM_WARP)-1:0]    rsp_wid_o,
  output logic [NUM_THREAD-1:0]          rsp_mask_o,
  output logic [XLEN-1:0]                rsp_pc_o,
  output logic                           rsp_flush_o,
  output logic [NUM_WARP*NUM_THREAD-1:0] active_mask_o,
  output logic [NUM_WARP-1:0]            stack_empty_o,
  output logic [31:0]                    err_o,
  input  logic                           err_clr_i
);

  localparam int         WW     = $clog2(NUM_WARP);
  localparam int         SPW    = $clog2(DEPTH + 1);
  localparam int         IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] c_OP_POP  = 3'd3;
  localparam logic [2:0] c_OP_PUSH = 3'd4;

  // Per-warp state
  logic [NUM_THREAD-1:0] r_active    [NUM_WARP];
  logic [SPW-1:0]        r_sp        [NUM_WARP];
  // Stack entries
  logic [NUM_THREAD-1:0] r_orig_mask [NUM_WARP][DEPTH];
  logic [NUM_THREAD-1:0] r_else_mask [NUM_WARP][DEPTH];
  logic [XLEN-1:0]       r_else_pc   [NUM_WARP][DEPTH];
  logic [XLEN-1:0]       r_reconv_pc [NUM_WARP][DEPTH];
  logic                  r_phase     [NUM_WARP][DEPTH];

  logic                  r_rsp_valid;
  logic [WW-1:0]         r_rsp_wid;
  logic [NUM_THREAD-1:0] r_rsp_mask;
  logic [XLEN-1:0]       r_rsp_pc;
  logic                  r_rsp_flush;
  logic [31:0]           r_err;

  logic                  w_accept;
  logic [NUM_THREAD-1:0] w_act;
  logic [SPW-1:0]        w_sp;
  logic [IDXW-1:0]       w_top;
  logic [IDXW-1:0]       w_push_idx;
  logic [NUM_THREAD-1:0] w_taken;
  logic [NUM_THREAD-1:0] w_not_taken;
  logic [NUM_THREAD-1:0] w_new_act;
  logic [XLEN-1:0]       w_pc;
  logic                  w_flush;
  logic                  w_do_push;
  logic                  w_do_phase;
  logic                  w_do_pop;
  logic [31:0]           w_err_set;

  // Launch takes the cycle; any request (same warp or not) is stalled.
  assign w_accept    = req_valid_i && !init_valid_i;
  assign req_ready_o = !init_valid_i;

  // Combinational read of the requesting warp's top entry (index sp-1).
  assign w_act       = r_active[req_wid_i];
  assign w_sp        = r_sp[req_wid_i];
  assign w_top       = IDXW'(w_sp - SPW'(1));
  assign w_push_idx  = IDXW'(w_sp);
  assign w_taken     = req_taken_mask_i & w_act;
  assign w_not_taken = w_act & ~w_taken;

  always_comb begin
    w_new_act  = w_act;
    w_pc       = req_fallthru_pc_i;
    w_flush    = 1'b0;
    w_do_push  = 1'b0;
    w_do_phase = 1'b0;
    w_do_pop   = 1'b0;
    w_err_set  = '0;
    case (req_op_i)
      c_OP_PUSH: begin
        if (w_taken == '0) begin
          // all threads fall through: keep fetching sequentially
        end else if (w_not_taken == '0) begin
          w_pc    = req_target_pc_i;
          w_flush = 1'b1;
        end else if (w_sp < SPW'(DEPTH)) begin
          w_do_push = 1'b1;
          w_new_act = w_taken;
          w_pc      = req_target_pc_i;
          w_flush   = 1'b1;
        end else begin
          w_err_set[5] = 1'b1;
        end
      end
      c_OP_POP: begin
        if (w_sp == '0) begin
          w_err_set[6] = 1'b1;
        end else if (!r_phase[req_wid_i][w_top]) begin
          // taken path done; switch to the pending else path
          w_do_phase = 1'b1;
          w_new_act  = r_else_mask[req_wid_i][w_top];
          w_pc       = r_else_pc[req_wid_i][w_top];
          w_flush    = 1'b1;
        end else begin
          // both paths done; reconverge
          w_do_pop  = 1'b1;
          w_new_act = r_orig_mask[req_wid_i][w_top];
          w_pc      = r_reconv_pc[req_wid_i][w_top];
          w_flush   = 1'b1;
        end
      end
      default: w_err_set[7] = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARP; w++) begin
        r_active[w] <= '0;
        r_sp[w]     <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          r_orig_mask[w][d] <= '0;
          r_else_mask[w][d] <= '0;
          r_else_pc[w][d]   <= '0;
          r_reconv_pc[w][d] <= '0;
          r_phase[w][d]     <= 1'b0;
        end
      end
      r_rsp_valid <= 1'b0;
      r_rsp_wid   <= '0;
      r_rsp_mask  <= '0;
      r_rsp_pc    <= '0;
      r_rsp_flush <= 1'b0;
      r_err       <= '0;
    end else begin
      r_rsp_valid <= w_accept;
      // A new error in the clearing cycle survives the clear.
      r_err <= (err_clr_i ? 32'd0 : r_err) | (w_accept ? w_err_set : 32'd0);

      if (init_valid_i) begin
        r_active[init_wid_i] <= init_mask_i;
        r_sp[init_wid_i]     <= '0;
      end else if (w_accept) begin
        r_active[req_wid_i] <= w_new_act;
        r_rsp_wid           <= req_wid_i;
        r_rsp_mask          <= w_new_act;
        r_rsp_pc            <= w_pc;
        r_rsp_flush         <= w_flush;
        if (w_do_push) begin
          r_orig_mask[req_wid_i][w_push_idx] <= w_act;
          r_else_mask[req_wid_i][w_push_idx] <= w_not_taken;
          r_else_pc[req_wid_i][w_push_idx]   <= req_fallthru_pc_i;
          r_reconv_pc[req_wid_i][w_push_idx] <= req_reconv_pc_i;
          r_phase[req_wid_i][w_push_idx]     <= 1'b0;
          r_sp[req_wid_i]                    <= w_sp + SPW'(1);
        end
        if (w_do_phase) begin
          r_phase[req_wid_i][w_top] <= 1'b1;
        end
        if (w_do_pop) begin
          r_sp[req_wid_i] <= w_sp - SPW'(1);
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_WARP; g++) begin : g_warp_out
      assign active_mask_o[g*NUM_THREAD +: NUM_THREAD] = r_active[g];
      assign stack_empty_o[g] = (r_sp[g] == '0);
    end
  endgenerate

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_wid_o   = r_rsp_wid;
  assign rsp_mask_o  = r_rsp_mask;
  assign rsp_pc_o    = r_rsp_pc;
  assign rsp_flush_o = r_rsp_flush;
  assign err_o       = r_err;

endmodule
`default_nettype wire
